// File: rtl/mem_dual_sequencer_pkg.sv
// Shared types and helpers for the dual-lane memory sequencer.
// Types and pure functions only: no latency and no backpressure of their own.
package mem_dual_sequencer_pkg;

    localparam int SEQ_ADDR_W  = 32;
    localparam int SEQ_DATA_W  = 32;
    localparam int SEQ_RADDR_W = 5;

    localparam int         MEM_LANES     = 2;
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        DONE,
        DRAIN
    } mem_seq_state_t;

    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [SEQ_ADDR_W-1:0]  addr;
        logic [SEQ_DATA_W-1:0]  wdata;
        logic [SEQ_DATA_W-1:0]  result;
        logic                   wreg_need;
        logic [SEQ_RADDR_W-1:0] wreg_addr;
        logic                   misalign;
    } lane_slot_t;

    function automatic logic lane_misaligned(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd | wr) && ((lsb & MISALIGN_MASK) != 2'b00);
    endfunction

    // A misaligned access never reaches the dcache; it is reported instead.
    function automatic logic lane_needs_port(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd | wr) && !lane_misaligned(rd, wr, lsb);
    endfunction

endpackage

// File: rtl/mem_lane_slot.sv
// Holds one memory lane of the bundle; captured on accept, result replaced on load return.
// Latency: 1 cycle from cap/ld_ret to slot; no backpressure (the top sequences writes).
module mem_lane_slot
    import mem_dual_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [SEQ_ADDR_W-1:0]  addr,
    input  logic [SEQ_DATA_W-1:0]  wdata,
    input  logic [SEQ_DATA_W-1:0]  result,
    input  logic                   wreg_need,
    input  logic [SEQ_RADDR_W-1:0] wreg_addr,
    input  logic                   ld_ret,
    input  logic [SEQ_DATA_W-1:0]  rdata,
    output lane_slot_t             slot,
    output logic                   needs_port
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (cap) begin
            slot <= '{rd:        rd,
                      wr:        wr,
                      addr:      addr,
                      wdata:     wdata,
                      result:    result,
                      wreg_need: wreg_need,
                      wreg_addr: wreg_addr,
                      misalign:  lane_misaligned(rd, wr, addr[1:0])};
        end else if (ld_ret) begin
            slot.result <= rdata;
        end
    end

    assign needs_port = (slot.rd | slot.wr) & ~slot.misalign;

endmodule

// File: rtl/mem_dual_sequencer.sv
// Serialises lane 0 then lane 1 of a captured bundle onto one dcache port; out_valid 2+ cycles after accept.
// Backpressure: in_ready only in IDLE; dc_req held stable until dc_gnt; results presented as one pulse.
module mem_dual_sequencer
    import mem_dual_sequencer_pkg::*;
#(
    parameter int ADDR_W  = SEQ_ADDR_W,
    parameter int DATA_W  = SEQ_DATA_W,
    parameter int RADDR_W = SEQ_RADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_read_ena,
    input  logic [1:0]               in_write_ena,
    input  logic [1:0][ADDR_W-1:0]   in_addr,
    input  logic [1:0][DATA_W-1:0]   in_wdata,
    input  logic [1:0][DATA_W-1:0]   in_result,
    input  logic [1:0]               in_wreg_need,
    input  logic [1:0][RADDR_W-1:0]  in_wreg_addr,
    input  logic                     flush,
    output logic                     dc_req,
    output logic                     dc_we,
    output logic [ADDR_W-1:0]        dc_addr,
    output logic [DATA_W-1:0]        dc_wdata,
    input  logic                     dc_gnt,
    input  logic                     dc_rvalid,
    input  logic [DATA_W-1:0]        dc_rdata,
    output logic                     out_valid,
    output logic [1:0][DATA_W-1:0]   out_result,
    output logic [1:0]               out_wreg_need,
    output logic [1:0][RADDR_W-1:0]  out_wreg_addr,
    output logic [1:0]               out_misalign
);

    mem_seq_state_t         state;
    lane_slot_t             slot     [MEM_LANES];
    logic [MEM_LANES-1:0]   slot_need;
    logic [MEM_LANES-1:0]   in_need;
    logic [MEM_LANES-1:0]   ld_ret;
    logic                   accept;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    assign ld_ret[0] = (state == WAIT0) & dc_rvalid;
    assign ld_ret[1] = (state == WAIT1) & dc_rvalid;

    for (genvar k = 0; k < MEM_LANES; k++) begin : g_lane
        assign in_need[k] = lane_needs_port(in_read_ena[k], in_write_ena[k], in_addr[k][1:0]);

        mem_lane_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .cap        (accept),
            .rd         (in_read_ena[k]),
            .wr         (in_write_ena[k]),
            .addr       (in_addr[k]),
            .wdata      (in_wdata[k]),
            .result     (in_result[k]),
            .wreg_need  (in_wreg_need[k]),
            .wreg_addr  (in_wreg_addr[k]),
            .ld_ret     (ld_ret[k]),
            .rdata      (dc_rdata),
            .slot       (slot[k]),
            .needs_port (slot_need[k])
        );
    end

    // The dcache request is fully registered, so it can never follow dc_gnt combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dc_req        <= 1'b0;
            dc_we         <= 1'b0;
            dc_addr       <= '0;
            dc_wdata      <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_wreg_need <= '0;
            out_wreg_addr <= '0;
            out_misalign  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_need[0]) begin
                            state    <= ISSUE0;
                            dc_req   <= 1'b1;
                            dc_we    <= in_write_ena[0] & ~in_read_ena[0];
                            dc_addr  <= in_addr[0];
                            dc_wdata <= in_wdata[0];
                        end else if (in_need[1]) begin
                            state    <= ISSUE1;
                            dc_req   <= 1'b1;
                            dc_we    <= in_write_ena[1] & ~in_read_ena[1];
                            dc_addr  <= in_addr[1];
                            dc_wdata <= in_wdata[1];
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE0: begin
                    if (dc_gnt) begin
                        if (slot[0].rd) begin
                            state  <= flush ? DRAIN : WAIT0;
                            dc_req <= 1'b0;
                        end else if (flush) begin
                            state  <= IDLE;
                            dc_req <= 1'b0;
                        end else if (slot_need[1]) begin
                            state    <= ISSUE1;
                            dc_we    <= slot[1].wr & ~slot[1].rd;
                            dc_addr  <= slot[1].addr;
                            dc_wdata <= slot[1].wdata;
                        end else begin
                            state  <= DONE;
                            dc_req <= 1'b0;
                        end
                    end else if (flush) begin
                        state  <= IDLE;
                        dc_req <= 1'b0;
                    end
                end
                WAIT0: begin
                    if (dc_rvalid) begin
                        if (flush) begin
                            state <= IDLE;
                        end else if (slot_need[1]) begin
                            state    <= ISSUE1;
                            dc_req   <= 1'b1;
                            dc_we    <= slot[1].wr & ~slot[1].rd;
                            dc_addr  <= slot[1].addr;
                            dc_wdata <= slot[1].wdata;
                        end else begin
                            state <= DONE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                ISSUE1: begin
                    if (dc_gnt) begin
                        dc_req <= 1'b0;
                        if (slot[1].rd) state <= flush ? DRAIN : WAIT1;
                        else            state <= flush ? IDLE  : DONE;
                    end else if (flush) begin
                        state  <= IDLE;
                        dc_req <= 1'b0;
                    end
                end
                WAIT1: begin
                    if (dc_rvalid)  state <= flush ? IDLE : DONE;
                    else if (flush) state <= DRAIN;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    for (int k = 0; k < MEM_LANES; k++) begin
                        out_result[k]    <= slot[k].result;
                        out_wreg_need[k] <= slot[k].wreg_need & ~slot[k].misalign;
                        out_wreg_addr[k] <= slot[k].wreg_addr;
                        out_misalign[k]  <= slot[k].misalign;
                    end
                    state <= IDLE;
                end
                DRAIN: begin
                    if (dc_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        dc_rvalid |-> (state inside {WAIT0, WAIT1, DRAIN}));

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (dc_req && !dc_gnt && !flush) |=> (dc_req && $stable(dc_addr) && $stable(dc_we)));

endmodule

// File: tb/tb_mem_dual_sequencer.sv
// Directed bench for mem_dual_sequencer: a scoreboard of expected dcache requests and commit bundles.
// Drives and samples on the falling edge; every wait is bounded.
module tb_mem_dual_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_read_ena;
    logic [1:0]        in_write_ena;
    logic [1:0][31:0]  in_addr;
    logic [1:0][31:0]  in_wdata;
    logic [1:0][31:0]  in_result;
    logic [1:0]        in_wreg_need;
    logic [1:0][4:0]   in_wreg_addr;
    logic              flush;
    logic              dc_req;
    logic              dc_we;
    logic [31:0]       dc_addr;
    logic [31:0]       dc_wdata;
    logic              dc_gnt;
    logic              dc_rvalid;
    logic [31:0]       dc_rdata;
    logic              out_valid;
    logic [1:0][31:0]  out_result;
    logic [1:0]        out_wreg_need;
    logic [1:0][4:0]   out_wreg_addr;
    logic [1:0]        out_misalign;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        logic [31:0] ldata;
        logic        need;
        logic [4:0]  wa;
    } tb_lane_t;

    typedef struct packed {
        logic [1:0][31:0] result;
        logic [1:0]       wreg_need;
        logic [1:0][4:0]  wreg_addr;
        logic [1:0]       misalign;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    exp_t exp_q [$];
    req_t req_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   ov_cnt   = 0;
    int   ov_before;

    mem_dual_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_read_ena   (in_read_ena),
        .in_write_ena  (in_write_ena),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_result     (in_result),
        .in_wreg_need  (in_wreg_need),
        .in_wreg_addr  (in_wreg_addr),
        .flush         (flush),
        .dc_req        (dc_req),
        .dc_we         (dc_we),
        .dc_addr       (dc_addr),
        .dc_wdata      (dc_wdata),
        .dc_gnt        (dc_gnt),
        .dc_rvalid     (dc_rvalid),
        .dc_rdata      (dc_rdata),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_wreg_need (out_wreg_need),
        .out_wreg_addr (out_wreg_addr),
        .out_misalign  (out_misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (out_valid) ov_cnt <= ov_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tb_lane_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] result,
                                    input logic [31:0] ldata, input logic need, input logic [4:0] wa);
        tb_lane_t l;
        l.rd = rd; l.wr = wr; l.addr = addr; l.wdata = wdata;
        l.result = result; l.ldata = ldata; l.need = need; l.wa = wa;
        return l;
    endfunction

    task automatic scramble();
        in_read_ena  = 2'($urandom);
        in_write_ena = 2'($urandom);
        in_wreg_need = 2'($urandom);
        for (int k = 0; k < 2; k++) begin
            in_addr[k]      = $urandom;
            in_wdata[k]     = $urandom;
            in_result[k]    = $urandom;
            in_wreg_addr[k] = 5'($urandom);
        end
    endtask

    // Presents one bundle for a single cycle and records what the dcache and commit sides must see.
    task automatic drive_bundle(input tb_lane_t l0, input tb_lane_t l1, input bit expect_out);
        tb_lane_t ln [2];
        exp_t     e;
        logic     mis, mem;
        ln[0] = l0;
        ln[1] = l1;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            mis = (ln[k].rd | ln[k].wr) && (ln[k].addr[1:0] != 2'b00);
            mem = (ln[k].rd | ln[k].wr) && !mis;
            e.result[k]    = (mem && ln[k].rd) ? ln[k].ldata : ln[k].result;
            e.wreg_need[k] = ln[k].need & ~mis;
            e.wreg_addr[k] = ln[k].wa;
            e.misalign[k]  = mis;
            if (mem) req_q.push_back('{we: ~ln[k].rd, addr: ln[k].addr, wdata: ln[k].wdata});
        end
        chk("accept_in_ready", in_ready, 1);
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_read_ena[k]  = ln[k].rd;
            in_write_ena[k] = ln[k].wr;
            in_addr[k]      = ln[k].addr;
            in_wdata[k]     = ln[k].wdata;
            in_result[k]    = ln[k].result;
            in_wreg_need[k] = ln[k].need;
            in_wreg_addr[k] = ln[k].wa;
        end
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        if (expect_out) exp_q.push_back(e);
    endtask

    // Acts as the dcache for one request; rv_delay = 0 means the load data is withheld.
    task automatic serve(input string tag, input int gnt_delay, input int rv_delay, input logic [31:0] rdata);
        int   n;
        req_t r;
        n = 0;
        while (!dc_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!dc_req) begin
            chk({tag, "_req_timeout"}, 0, 1);
            return;
        end
        if (req_q.size() == 0) begin
            chk({tag, "_unexpected_req"}, 1, 0);
            return;
        end
        r = req_q.pop_front();
        chk({tag, "_we"}, dc_we, r.we);
        chk({tag, "_addr"}, dc_addr, r.addr);
        if (r.we) chk({tag, "_wdata"}, dc_wdata, r.wdata);
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            chk({tag, "_req_held"}, dc_req, 1);
            chk({tag, "_addr_held"}, dc_addr, r.addr);
            chk({tag, "_busy"}, in_ready, 0);
        end
        dc_gnt = 1'b1;
        @(negedge clk);
        dc_gnt = 1'b0;
        if (!r.we && rv_delay > 0) begin
            repeat (rv_delay - 1) @(negedge clk);
            dc_rvalid = 1'b1;
            dc_rdata  = rdata;
            @(negedge clk);
            dc_rvalid = 1'b0;
            dc_rdata  = $urandom;
        end
    endtask

    task automatic wait_out(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_out_timeout"}, 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_out"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_result0"}, out_result[0], e.result[0]);
        chk({tag, "_result1"}, out_result[1], e.result[1]);
        chk({tag, "_wreg_need"}, out_wreg_need, e.wreg_need);
        chk({tag, "_wreg_addr"}, out_wreg_addr, e.wreg_addr);
        chk({tag, "_misalign"}, out_misalign, e.misalign);
        @(negedge clk);
        chk({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        dc_gnt    = 1'b0;
        dc_rvalid = 1'b0;
        dc_rdata  = $urandom;
        scramble();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dc_req", dc_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_misalign", out_misalign, 0);

        // 1: no memory lanes, out_valid on the second edge after accept
        drive_bundle(mk(0, 0, 32'h0, 32'h0, 32'h11, 32'h0, 1, 5'd3),
                     mk(0, 0, 32'h0, 32'h0, 32'h22, 32'h0, 1, 5'd4), 1);
        chk("t1_lat_early", out_valid, 0);
        chk("t1_no_req_a", dc_req, 0);
        @(negedge clk);
        chk("t1_lat_due", out_valid, 1);
        chk("t1_no_req_b", dc_req, 0);
        wait_out("t1");

        // 2: lane-0 store then lane-1 load of the same word
        drive_bundle(mk(0, 1, 32'h100, 32'hDEAD, 32'h5, 32'h0, 0, 5'd0),
                     mk(1, 0, 32'h100, 32'h0, 32'h6, 32'hDEAD, 1, 5'd9), 1);
        serve("t2_st", 0, 0, 32'h0);
        serve("t2_ld", 0, 2, 32'hDEAD);
        wait_out("t2");

        // 3: two loads, lane 0 grant withheld; lane 1 has read and write both set
        drive_bundle(mk(1, 0, 32'h200, 32'h0, 32'h7, 32'hA0, 1, 5'd10),
                     mk(1, 1, 32'h204, 32'hFFFF, 32'h8, 32'hA1, 1, 5'd11), 1);
        serve("t3_ld0", 3, 1, 32'hA0);
        serve("t3_ld1", 0, 3, 32'hA1);
        wait_out("t3");

        // 4: misaligned lane 1 is reported and never issued
        drive_bundle(mk(1, 0, 32'h300, 32'h0, 32'h9, 32'hB0, 1, 5'd12),
                     mk(1, 0, 32'h102, 32'h0, 32'h44, 32'h0, 1, 5'd13), 1);
        serve("t4_ld0", 1, 1, 32'hB0);
        wait_out("t4");
        chk("t4_no_extra_req", req_q.size(), 0);

        // 5: flush while waiting for load data; late data drained, no commit
        ov_before = ov_cnt;
        drive_bundle(mk(1, 0, 32'h400, 32'h0, 32'h1, 32'h0, 1, 5'd1),
                     mk(0, 0, 32'h0, 32'h0, 32'h2, 32'h0, 1, 5'd2), 0);
        serve("t5_ld0", 0, 0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_drain_busy", in_ready, 0);
        chk("t5_drain_no_req", dc_req, 0);
        @(negedge clk);
        dc_rvalid = 1'b1;
        dc_rdata  = 32'hBAD;
        @(negedge clk);
        dc_rvalid = 1'b0;
        chk("t5_idle_after_drain", in_ready, 1);
        chk("t5_no_out", ov_cnt, ov_before);
        drive_bundle(mk(0, 0, 32'h0, 32'h0, 32'h55, 32'h0, 1, 5'd5),
                     mk(0, 0, 32'h0, 32'h0, 32'h66, 32'h0, 0, 5'd6), 1);
        wait_out("t5_next");

        // 6: reset while lane 1 waits for its load data
        drive_bundle(mk(0, 1, 32'h500, 32'h77, 32'h0, 32'h0, 0, 5'd7),
                     mk(1, 0, 32'h504, 32'h0, 32'h0, 32'h0, 1, 5'd8), 0);
        serve("t6_st", 0, 0, 32'h0);
        serve("t6_ld", 0, 0, 32'h0);
        chk("t6_busy_before_rst", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_dc_req", dc_req, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_result", out_result, 0);
        chk("t6_out_wreg_need", out_wreg_need, 0);
        chk("t6_out_wreg_addr", out_wreg_addr, 0);
        chk("t6_out_misalign", out_misalign, 0);
        rst = 1'b0;
        @(negedge clk);
        drive_bundle(mk(0, 0, 32'h0, 32'h0, 32'h99, 32'h0, 1, 5'd14),
                     mk(0, 0, 32'h0, 32'h0, 32'hAA, 32'h0, 1, 5'd15), 1);
        wait_out("t6_after");
        chk("end_exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
